// File: rtl/countdown_game_multi.sv
// Multi-player countdown game: loads a start value, counts down once per
// TICK_CYCLES clocks, and records each player's single stop press. A player
// wins when the captured count is within TOLERANCE of zero. The game ends
// when every player has stopped or the count times out at zero.
module countdown_game_multi #(
    parameter int TICK_CYCLES = 50000000,
    parameter int WIDTH       = 7,
    parameter int PLAYERS     = 2,
    parameter int TOLERANCE   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     hide,
    input  logic [WIDTH-1:0]         from,
    input  logic [PLAYERS-1:0]       stop,
    output logic [WIDTH-1:0]         display,
    output logic                     running,
    output logic                     done,
    output logic [PLAYERS-1:0]       win,
    output logic [PLAYERS-1:0]       lose,
    output logic [PLAYERS*WIDTH-1:0] stopped_at
);

    localparam int PW = $clog2(TICK_CYCLES + 1);
    localparam logic [PW-1:0]    TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [WIDTH-1:0] TOL       = WIDTH'(TOLERANCE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         count_q, count_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [PLAYERS-1:0]       stop_q;
    logic [PLAYERS-1:0]       stopped_q, stopped_d;
    logic [PLAYERS-1:0]       win_q, win_d;
    logic [PLAYERS-1:0]       lose_q, lose_d;
    logic [PLAYERS*WIDTH-1:0] cap_q, cap_d;
    logic [PLAYERS-1:0]       press;
    logic                     tick;

    // A held button produces one press: only the rising edge counts.
    assign press = stop & ~stop_q;

    // Next-state logic: start overrides everything, otherwise advance the
    // countdown, capture fresh presses and detect the end of the game.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        stopped_d = stopped_q;
        win_d     = win_q;
        lose_d    = lose_q;
        cap_d     = cap_q;
        tick      = 1'b0;
        if (start) begin
            state_d   = ST_RUN;
            count_d   = from;
            presc_d   = '0;
            stopped_d = '0;
            win_d     = '0;
            lose_d    = '0;
            cap_d     = '0;
        end else if (state_q == ST_RUN) begin
            tick    = (presc_q == TICK_LAST);
            presc_d = tick ? '0 : presc_q + 1'b1;
            // Presses capture the count as it stands before this edge's tick.
            for (int i = 0; i < PLAYERS; i++) begin
                if (press[i] && !stopped_q[i]) begin
                    cap_d[i*WIDTH +: WIDTH] = count_q;
                    stopped_d[i]            = 1'b1;
                    win_d[i]                = (count_q <= TOL);
                    lose_d[i]               = !(count_q <= TOL);
                end
            end
            if (tick) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    // Timeout: anyone who has not stopped (including this
                    // edge's presses, already recorded above) loses.
                    lose_d    = lose_d | ~stopped_d;
                    stopped_d = '1;
                end
            end
            if (&stopped_d) begin
                state_d = ST_DONE;
            end
        end
    end

    // State registers; reset returns the game to an idle, cleared board.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            stop_q    <= '0;
            stopped_q <= '0;
            win_q     <= '0;
            lose_q    <= '0;
            cap_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            stop_q    <= stop;
            stopped_q <= stopped_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
            cap_q     <= cap_d;
        end
    end

    assign running    = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign display    = (hide && running) ? '1 : count_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign stopped_at = cap_q;

endmodule

// File: tb/tb_countdown_game_multi.sv
// Bench for countdown_game_multi: scenario table, reset sequence and random
// stimulus, all compared every cycle against an elapsed-time game model.
module tb_countdown_game_multi;

    localparam int T   = 4;
    localparam int W   = 7;
    localparam int P   = 2;
    localparam int TOL = 0;

    logic             clk = 1'b0;
    logic             reset_r = 1'b1;
    logic             start_r = 1'b0;
    logic             hide_r = 1'b0;
    logic [W-1:0]     from_r = '0;
    logic [P-1:0]     stop_r = '0;
    logic [W-1:0]     display;
    logic             running;
    logic             done;
    logic [P-1:0]     win;
    logic [P-1:0]     lose;
    logic [P*W-1:0]   stopped_at;

    int checks = 0;
    int errors = 0;

    countdown_game_multi #(
        .TICK_CYCLES(T), .WIDTH(W), .PLAYERS(P), .TOLERANCE(TOL)
    ) dut (
        .clk(clk), .reset(reset_r), .start(start_r), .hide(hide_r),
        .from(from_r), .stop(stop_r), .display(display), .running(running),
        .done(done), .win(win), .lose(lose), .stopped_at(stopped_at)
    );

    always #5 clk = ~clk;

    // Model: game described by elapsed edges since start, not by a prescaler.
    bit       m_run, m_done;
    int       m_f, m_c, m_cnt;
    bit [1:0] m_prev, m_res, m_win, m_lose;
    int       m_cap [2];

    task automatic model_reset();
        m_run = 0; m_done = 0; m_f = 0; m_c = 0; m_cnt = 0;
        m_prev = 0; m_res = 0; m_win = 0; m_lose = 0;
        m_cap[0] = 0; m_cap[1] = 0;
    endtask

    task automatic model_edge();
        bit [1:0] pr;
        if (reset_r) begin
            model_reset();
        end else begin
            pr = stop_r & ~m_prev;
            m_prev = stop_r;
            if (start_r) begin
                m_run = 1; m_done = 0; m_f = int'(from_r); m_c = 0; m_cnt = m_f;
                m_res = 0; m_win = 0; m_lose = 0; m_cap[0] = 0; m_cap[1] = 0;
            end else if (m_run) begin
                m_c++;
                for (int i = 0; i < P; i++) begin
                    if (pr[i] && !m_res[i]) begin
                        m_cap[i]  = m_f - (m_c - 1) / T;
                        m_win[i]  = (m_cap[i] <= TOL);
                        m_lose[i] = !(m_cap[i] <= TOL);
                        m_res[i]  = 1;
                    end
                end
                if (m_c == (m_f + 1) * T) begin
                    for (int i = 0; i < P; i++) if (!m_res[i]) m_lose[i] = 1;
                    m_run = 0; m_done = 1;
                end else begin
                    m_cnt = m_f - m_c / T;
                    if (m_res == 2'b11) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [W-1:0]   e_disp;
        logic [P*W-1:0] e_cap;
        e_disp = (hide_r && m_run) ? 7'h7F : W'(m_cnt);
        e_cap  = {W'(m_cap[1]), W'(m_cap[0])};
        chk("display", 32'(display), 32'(e_disp));
        chk("running", 32'(running), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("win", 32'(win), 32'(m_win));
        chk("lose", 32'(lose), 32'(m_lose));
        chk("stopped_at", 32'(stopped_at), 32'(e_cap));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    typedef struct {
        int       from;
        bit       hide;
        int       p0c;   // edge after start where P0 first presses (0 = never)
        int       p0h;   // cycles P0 holds the button
        int       p1c;
        int       p1h;
        bit [1:0] ewin;
        bit [1:0] elose;
        int       ecap0;
        int       ecap1;
        int       edone; // edge after start at which done appears
    } vec_t;

    vec_t vecs [6];

    initial begin
        int done_at;
        vecs[0] = '{3, 0,  0, 0,  0, 0, 2'b00, 2'b11, 0, 0, 16}; // timeout, nobody pressed
        vecs[1] = '{3, 0, 14, 1,  6, 1, 2'b01, 2'b10, 0, 2, 14}; // P1 at 2, P0 at 0
        vecs[2] = '{3, 0,  4, 20, 14, 1, 2'b10, 2'b01, 3, 0, 14}; // P0 on tick edge, held
        vecs[3] = '{3, 0, 16, 1,  0, 0, 2'b01, 2'b10, 0, 0, 16}; // P0 on timeout edge
        vecs[4] = '{0, 0,  2, 1,  0, 0, 2'b01, 2'b10, 0, 0,  4}; // from=0 times out at T
        vecs[5] = '{5, 1,  3, 1,  3, 1, 2'b00, 2'b11, 5, 5,  3}; // hidden, simultaneous

        model_reset();
        step();
        step();
        chk("reset_display", 32'(display), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        reset_r = 1'b0;
        step();

        // Table-driven scenarios; each one restarts from the previous DONE.
        for (int v = 0; v < 6; v++) begin
            start_r = 1'b1; from_r = W'(vecs[v].from); hide_r = vecs[v].hide;
            step();
            start_r = 1'b0;
            done_at = -1;
            for (int k = 1; k <= 40; k++) begin
                stop_r[0] = (vecs[v].p0c != 0) && (k >= vecs[v].p0c) && (k < vecs[v].p0c + vecs[v].p0h);
                stop_r[1] = (vecs[v].p1c != 0) && (k >= vecs[v].p1c) && (k < vecs[v].p1c + vecs[v].p1h);
                step();
                if (done && done_at < 0) done_at = k;
            end
            stop_r = '0;
            chk("tbl_win", 32'(win), 32'(vecs[v].ewin));
            chk("tbl_lose", 32'(lose), 32'(vecs[v].elose));
            chk("tbl_cap0", 32'(stopped_at[W-1:0]), 32'(vecs[v].ecap0));
            chk("tbl_cap1", 32'(stopped_at[2*W-1:W]), 32'(vecs[v].ecap1));
            chk("tbl_done_edge", 32'(done_at), 32'(vecs[v].edone));
            $display("scenario %0d from=%0d win=%b lose=%b stopped_at=%h done_at=%0d",
                     v, vecs[v].from, win, lose, stopped_at, done_at);
        end

        // Async reset mid-cycle at count 2 with P0 already stopped.
        hide_r = 1'b0; start_r = 1'b1; from_r = 7'd3;
        step();
        start_r = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            stop_r[0] = (k == 6);
            step();
        end
        stop_r = '0;
        #2 reset_r = 1'b1;
        #1;
        chk("async_display", 32'(display), 32'd0);
        chk("async_running", 32'(running), 32'd0);
        chk("async_win", 32'(win), 32'd0);
        chk("async_lose", 32'(lose), 32'd0);
        chk("async_cap", 32'(stopped_at), 32'd0);
        model_reset();
        stop_r = 2'b11;
        step();
        stop_r = 2'b00;
        step();
        reset_r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stop_r = (k % 2 == 0) ? 2'b11 : 2'b00;
            step();
        end
        $display("reset sequence done running=%b done=%b win=%b lose=%b", running, done, win, lose);

        // Random stimulus against the model.
        for (int n = 0; n < 600; n++) begin
            reset_r = ($urandom_range(0, 249) == 0);
            start_r = ($urandom_range(0, 29) == 0);
            from_r  = W'($urandom_range(0, 5));
            hide_r  = 1'($urandom_range(0, 1));
            stop_r[0] = ($urandom_range(0, 5) == 0);
            stop_r[1] = ($urandom_range(0, 5) == 0);
            step();
        end
        $display("random phase done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
